// File: rtl/mem_port_arbiter.sv
// Single-owner sequencer for the one-port data memory; loads win arbitration, stores are forced through after STARVE_LIMIT loads.
// Grants are combinational in IDLE, done pulses one cycle after mem_ack_i; requests are held off while an access is outstanding.
module mem_port_arbiter #(
    parameter int ADDR_LEN     = 32,
    parameter int DATA_LEN     = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                load_req_i,
    input  logic [ADDR_LEN-1:0] load_addr_i,
    output logic                load_gnt_o,
    output logic                load_done_o,
    output logic [DATA_LEN-1:0] load_data_o,
    input  logic                store_req_i,
    input  logic [ADDR_LEN-1:0] store_addr_i,
    input  logic [DATA_LEN-1:0] store_data_i,
    output logic                store_gnt_o,
    output logic                store_done_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_LEN-1:0] mem_addr_o,
    output logic [DATA_LEN-1:0] mem_wdata_o,
    input  logic                mem_ack_i,
    input  logic [DATA_LEN-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_LD = 2'd1,
        BUSY_ST = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    starve_q, starve_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [DATA_LEN-1:0] wdata_q, wdata_d;
    logic [DATA_LEN-1:0] rdata_q, rdata_d;
    logic                ld_done_q, ld_done_d;
    logic                st_done_q, st_done_d;
    logic                ld_gnt, st_gnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ld_done_q <= 1'b0;
            st_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ld_done_q <= ld_done_d;
            st_done_q <= st_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ld_done_d = 1'b0;
        st_done_d = 1'b0;
        ld_gnt    = 1'b0;
        st_gnt    = 1'b0;
        case (state_q)
            IDLE: begin
                // Grants are gated by reset so the combinational pulses also read 0 while reset is held.
                if (!reset_i) begin
                    if (store_req_i && (!load_req_i || starve_q >= CNT_LIMIT)) begin
                        st_gnt = 1'b1;
                    end else if (load_req_i) begin
                        ld_gnt = 1'b1;
                    end
                end
                if (st_gnt) begin
                    state_d  = BUSY_ST;
                    addr_d   = store_addr_i;
                    wdata_d  = store_data_i;
                    starve_d = '0;
                end else if (ld_gnt) begin
                    state_d = BUSY_LD;
                    addr_d  = load_addr_i;
                    if (store_req_i && starve_q != CNT_MAX) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            BUSY_LD: begin
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    ld_done_d = 1'b1;
                    rdata_d   = mem_rdata_i;
                end
            end
            BUSY_ST: begin
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    st_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_gnt_o   = ld_gnt;
    assign store_gnt_o  = st_gnt;
    assign load_done_o  = ld_done_q;
    assign store_done_o = st_done_q;
    assign load_data_o  = rdata_q;
    assign mem_req_o    = (state_q != IDLE);
    assign mem_we_o     = (state_q == BUSY_ST);
    assign mem_addr_o   = (state_q != IDLE) ? addr_q : '0;
    assign mem_wdata_o  = (state_q == BUSY_ST) ? wdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter against a transaction-level reference model.
// Expected grants, done events and per-cycle bus values are queued with their cycle number and checked by a separate monitor.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;
    localparam int CMAX  = 7;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        load_req_i = 1'b0;
    logic [31:0] load_addr_i = '0;
    logic        load_gnt_o, load_done_o;
    logic [31:0] load_data_o;
    logic        store_req_i = 1'b0;
    logic [31:0] store_addr_i = '0;
    logic [31:0] store_data_i = '0;
    logic        store_gnt_o, store_done_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    mem_port_arbiter #(
        .ADDR_LEN(32), .DATA_LEN(32), .STARVE_LIMIT(LIMIT), .CNT_W(3)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .load_req_i(load_req_i), .load_addr_i(load_addr_i),
        .load_gnt_o(load_gnt_o), .load_done_o(load_done_o), .load_data_o(load_data_o),
        .store_req_i(store_req_i), .store_addr_i(store_addr_i), .store_data_i(store_data_i),
        .store_gnt_o(store_gnt_o), .store_done_o(store_done_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int cyc; int kind; logic [31:0] data; } ev_t;
    typedef struct { int cyc; logic req; logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] ld; } bus_t;

    ev_t  exp_gnt[$];
    ev_t  exp_done[$];
    bus_t exp_bus[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Requester / memory intent
    bit          ld_want = 0, st_want = 0, spur_en = 0, rd_fix_en = 0;
    logic [31:0] ld_addr = '0, st_addr = '0, st_data = '0, rd_fix = '0;
    int          wait_sel = 0;

    // Reference model: kind 0 = idle, 1 = load in flight, 2 = store in flight
    int          m_busy = 0, m_starve = 0, m_wait = 0, m_tgt = 0;
    logic [31:0] m_addr = '0, m_data = '0, m_ld = '0;

    task automatic note(input bit ok, input string name, input logic [159:0] got, input logic [159:0] want);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_starve = 0; m_wait = 0; m_ld = '0; m_addr = '0; m_data = '0;
        ld_want = 0; st_want = 0;
        exp_done.delete();
    endtask

    task automatic model_eval();
        bus_t b;
        ev_t  e;
        b.cyc = cyc; b.req = (m_busy != 0); b.we = (m_busy == 2);
        b.addr = b.req ? m_addr : 32'h0;
        b.wdata = b.we ? m_data : 32'h0;
        b.ld = m_ld;
        exp_bus.push_back(b);
        if (m_busy == 0) begin
            if (store_req_i && (!load_req_i || m_starve >= LIMIT)) begin
                e.cyc = cyc; e.kind = 2; e.data = 32'h0; exp_gnt.push_back(e);
                m_busy = 2; m_addr = store_addr_i; m_data = store_data_i; m_starve = 0; st_want = 0;
            end else if (load_req_i) begin
                e.cyc = cyc; e.kind = 1; e.data = 32'h0; exp_gnt.push_back(e);
                m_busy = 1; m_addr = load_addr_i; ld_want = 0;
                if (store_req_i) m_starve = (m_starve < CMAX) ? m_starve + 1 : CMAX;
            end
            m_wait = 0;
            m_tgt = (wait_sel < 0) ? int'($urandom_range(0, 3)) : wait_sel;
        end else if (mem_ack_i) begin
            e.cyc = cyc + 1; e.kind = m_busy; e.data = mem_rdata_i; exp_done.push_back(e);
            if (m_busy == 1) m_ld = mem_rdata_i;
            m_busy = 0;
        end else begin
            m_wait++;
        end
    endtask

    task automatic step();
        @(posedge clk_i); #1;
        cyc++;
        reset_i = 1'b0;
        load_req_i = ld_want; load_addr_i = ld_addr;
        store_req_i = st_want; store_addr_i = st_addr; store_data_i = st_data;
        mem_rdata_i = rd_fix_en ? rd_fix : $urandom;
        if (m_busy != 0) mem_ack_i = (m_wait >= m_tgt);
        else mem_ack_i = spur_en && ($urandom_range(0, 2) == 0);
        model_eval();
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
            cyc++;
            reset_i = 1'b1;
            load_req_i = 1'b0; store_req_i = 1'b0; mem_ack_i = 1'b0;
            model_clear();
        end
    endtask

    task automatic rand_phase(input int n, input int pl, input int ps);
        repeat (n) begin
            if (!ld_want && $urandom_range(0, 99) < pl) begin ld_want = 1; ld_addr = $urandom; end
            if (!st_want && $urandom_range(0, 99) < ps) begin st_want = 1; st_addr = $urandom; st_data = $urandom; end
            step();
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk_i) begin
        bus_t         b;
        ev_t          e;
        int           k;
        logic [159:0] all;
        if (reset_i) begin
            all = {27'h0, load_gnt_o, load_done_o, load_data_o, store_gnt_o, store_done_o,
                   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o};
            note(all == '0, "reset_outputs", all, '0);
        end else begin
            if (exp_bus.size() == 0) begin
                note(0, "bus_underflow", '0, '0);
            end else begin
                b = exp_bus.pop_front();
                note(b.cyc == cyc &&
                     {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, load_data_o} == {b.req, b.we, b.addr, b.wdata, b.ld},
                     "bus", {62'h0, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, load_data_o},
                     {62'h0, b.req, b.we, b.addr, b.wdata, b.ld});
            end
            if (load_gnt_o || store_gnt_o) begin
                k = load_gnt_o ? 1 : 2;
                if (exp_gnt.size() != 0 && exp_gnt[0].cyc == cyc) begin
                    e = exp_gnt.pop_front();
                    note(k == e.kind && !(load_gnt_o && store_gnt_o), "grant",
                         {158'h0, store_gnt_o, load_gnt_o}, 160'(e.kind));
                end else begin
                    note(0, "grant_unexpected", {158'h0, store_gnt_o, load_gnt_o}, '0);
                end
            end
            while (exp_gnt.size() != 0 && exp_gnt[0].cyc <= cyc) begin
                e = exp_gnt.pop_front();
                note(0, "grant_missing", '0, 160'(e.kind));
            end
            if (load_done_o || store_done_o) begin
                k = load_done_o ? 1 : 2;
                if (exp_done.size() != 0 && exp_done[0].cyc == cyc) begin
                    e = exp_done.pop_front();
                    note(k == e.kind && !(load_done_o && store_done_o) && (k != 1 || load_data_o == e.data),
                         "done", {94'h0, store_done_o, load_done_o, load_data_o, 32'h0},
                         {94'h0, e.kind == 2, e.kind == 1, (e.kind == 1) ? e.data : load_data_o, 32'h0});
                end else begin
                    note(0, "done_unexpected", {158'h0, store_done_o, load_done_o}, '0);
                end
            end
            while (exp_done.size() != 0 && exp_done[0].cyc <= cyc) begin
                e = exp_done.pop_front();
                note(0, "done_missing", '0, 160'(e.kind));
            end
        end
    end

    initial begin
        do_reset(2);

        // Single load, ack two cycles after mem_req_o rises
        rd_fix_en = 1; rd_fix = 32'hDEADBEEF; wait_sel = 2;
        ld_want = 1; ld_addr = 32'h0000_1000;
        repeat (6) step();

        // Single store, zero-wait ack
        wait_sel = 0;
        st_want = 1; st_addr = 32'h0000_2004; st_data = 32'h1234_5678;
        repeat (4) step();

        // Simultaneous requests: load first, store once load drops
        ld_want = 1; ld_addr = 32'h0000_0040; st_want = 1; st_addr = 32'h0000_0080; st_data = 32'hA5A5_0001;
        repeat (6) step();
        rd_fix_en = 0;

        // Both requesters held high continuously: starvation forcing
        rand_phase(40, 100, 100);
        rand_phase(8, 0, 0);

        // Reset in the middle of a load, then re-issue
        wait_sel = 8; ld_want = 1; ld_addr = 32'h0000_3000;
        repeat (3) step();
        do_reset(2);
        wait_sel = 1; ld_want = 1; ld_addr = 32'h0000_3000;
        repeat (5) step();

        // Spurious acks while idle with no requests
        spur_en = 1; wait_sel = 0;
        rand_phase(12, 0, 0);

        // Random traffic with random memory latency
        wait_sel = -1;
        rand_phase(400, 40, 40);
        do_reset(1);
        rand_phase(300, 70, 50);
        rand_phase(300, 15, 90);

        spur_en = 0; wait_sel = 0;
        rand_phase(20, 0, 0);
        @(negedge clk_i); #1;
        note(exp_gnt.size() == 0, "grant_leftover", 160'(exp_gnt.size()), '0);
        note(exp_done.size() == 0, "done_leftover", 160'(exp_done.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
